reg_file_sb: RTL

- Architectural register file (32 x 32-bit) with an integrated long-latency scoreboard.
- Sits at the write end of the forwarding path:
  - accepts the write-back stream (WB port);
  - serves the two ID-stage read ports, with same-cycle write-through.
- Tracks destination registers of in-flight long-latency ops (load, mul/div) and raises a stall to ID on RAW/WAW conflicts the EX/MEM/WB forwarding network cannot cover.

---
 rtl/reg_file_sb.sv | 101 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Architectural register file with write-through read ports and a long-latency
// scoreboard that stalls ID on RAW/WAW hazards against in-flight ops.
module reg_file_sb #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_reg1_raddr_i,
  input  logic [4:0]         id_reg2_raddr_i,
  input  logic               id_reg1_RE_i,
  input  logic               id_reg2_RE_i,
  input  logic [4:0]         id_reg_waddr_i,
  input  logic               id_sb_set_i,
  input  logic               id_flush_i,
  input  logic [4:0]         wb_reg_waddr_i,
  input  logic [XLEN-1:0]    wb_op_c_i,
  input  logic               wb_reg_we_i,
  input  logic               wb_sb_clr_i,
  output logic [XLEN-1:0]    rf_reg1_rdata_o,
  output logic [XLEN-1:0]    rf_reg2_rdata_o,
  output logic               rf_stall_o,
  output logic [REG_NUM-1:0] rf_busy_o,
  output logic               rf_sb_err_o
);

  logic [XLEN-1:0]    regs_reg [REG_NUM];
  logic [REG_NUM-1:0] busy_reg;
  logic [REG_NUM-1:0] busy_next;
  logic [REG_NUM-1:0] clr_vec;
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] eff_busy;
  logic               err_reg;
  logic               wb_write;
  logic               clr;
  logic               set;
  logic               raw_waw;

  assign wb_write = wb_reg_we_i && (wb_reg_waddr_i != 5'd0);
  assign clr      = wb_write && wb_sb_clr_i;

  // Register 0 is never enabled, so it stays at its reset value of zero.
  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_regs
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (wb_write && (wb_reg_waddr_i == 5'(gi))) begin
          regs_reg[gi] <= wb_op_c_i;
        end
      end
    end
  endgenerate

  assign rf_reg1_rdata_o =
      (!id_reg1_RE_i || id_reg1_raddr_i == 5'd0)              ? '0 :
      (wb_reg_we_i && wb_reg_waddr_i == id_reg1_raddr_i)      ? wb_op_c_i :
                                                                regs_reg[id_reg1_raddr_i];
  assign rf_reg2_rdata_o =
      (!id_reg2_RE_i || id_reg2_raddr_i == 5'd0)              ? '0 :
      (wb_reg_we_i && wb_reg_waddr_i == id_reg2_raddr_i)      ? wb_op_c_i :
                                                                regs_reg[id_reg2_raddr_i];

  always_comb begin
    clr_vec = '0;
    if (clr) clr_vec[wb_reg_waddr_i] = 1'b1;
  end

  // A completion writing back this cycle is covered by the bypass, not busy.
  assign eff_busy = busy_reg & ~clr_vec;

  assign raw_waw = (id_reg1_RE_i && eff_busy[id_reg1_raddr_i]) ||
                   (id_reg2_RE_i && eff_busy[id_reg2_raddr_i]) ||
                   (id_sb_set_i  && eff_busy[id_reg_waddr_i]);
  assign rf_stall_o = raw_waw && !id_flush_i;

  assign set = id_sb_set_i && !rf_stall_o && !id_flush_i && (id_reg_waddr_i != 5'd0);

  always_comb begin
    set_vec = '0;
    if (set) set_vec[id_reg_waddr_i] = 1'b1;
  end

  // Set is OR'd after the clear so a same-cycle reissue to that register wins.
  assign busy_next = eff_busy | set_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (clr && !busy_reg[wb_reg_waddr_i]) err_reg <= 1'b1;
    end
  end

  assign rf_busy_o   = busy_reg;
  assign rf_sb_err_o = err_reg;

endmodule
